// File: rtl/dmem_display_scanner.sv
// dmem_display_scanner
//   Debug front-end for the processor board. Drives the data-memory read
//   address (auto-scanning all 16 locations, or frozen/stepped by the user),
//   captures the returned byte every cycle and multiplexes address and data
//   onto a 4-digit common-anode seven-segment display. Read-only observer.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   hold          async: 1 freezes the address and enables manual stepping
//   step          async: rising edge advances the address while hold is set
//   data_on_dmem  byte read back for addr_on_dmem (combinational read)
//   addr_on_dmem  dmem address being observed
//   an            digit anodes, active-low, bit 3 = leftmost digit
//   seg           segments, active-low, bit0 = a .. bit6 = g
//   dp            decimal point, active-low
//
// Display layout (left to right): address, blank with dp, data[7:4], data[3:0].

module dmem_display_scanner #(
  parameter int unsigned DWELL_CYCLES   = 100_000_000,
  parameter int unsigned REFRESH_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       step,
  input  logic [7:0] data_on_dmem,
  output logic [3:0] addr_on_dmem,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned DwellW   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned RefreshW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DwellW-1:0]   DwellLast   = DwellW'(DWELL_CYCLES - 1);
  localparam logic [RefreshW-1:0] RefreshLast = RefreshW'(REFRESH_CYCLES - 1);

  // Synchronizers and step edge detect
  logic hold_s1_q, hold_s2_q;
  logic step_s1_q, step_s2_q, step_prev_q;
  logic step_pulse_q;

  // Scan and refresh state
  logic [DwellW-1:0]   dwell_q, dwell_d;
  logic [3:0]          addr_q, addr_d;
  logic [RefreshW-1:0] refresh_q, refresh_d;
  logic [1:0]          digit_sel_q, digit_sel_d;
  logic [7:0]          data_q;

  // Registered display outputs
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_s1_q    <= 1'b0;
      hold_s2_q    <= 1'b0;
      step_s1_q    <= 1'b0;
      step_s2_q    <= 1'b0;
      step_prev_q  <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      hold_s1_q    <= hold;
      hold_s2_q    <= hold_s1_q;
      step_s1_q    <= step;
      step_s2_q    <= step_s1_q;
      step_prev_q  <= step_s2_q;
      step_pulse_q <= step_s2_q & ~step_prev_q;
    end
  end

  // Hold has priority over the dwell terminal count; a step pulse only counts
  // while the synchronized hold is still high in the cycle it is consumed.
  always_comb begin
    dwell_d = dwell_q;
    addr_d  = addr_q;
    if (hold_s2_q) begin
      dwell_d = '0;
      if (step_pulse_q) begin
        addr_d = addr_q + 4'd1;
      end
    end else if (dwell_q == DwellLast) begin
      dwell_d = '0;
      addr_d  = addr_q + 4'd1;
    end else begin
      dwell_d = dwell_q + DwellW'(1);
    end
  end

  always_comb begin
    refresh_d   = refresh_q + RefreshW'(1);
    digit_sel_d = digit_sel_q;
    if (refresh_q == RefreshLast) begin
      refresh_d   = '0;
      digit_sel_d = digit_sel_q + 2'd1;
    end
  end

  always_comb begin
    an_d  = ~(4'b0001 << digit_sel_q);
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    unique case (digit_sel_q)
      2'd0: seg_d = hex7(data_q[3:0]);
      2'd1: seg_d = hex7(data_q[7:4]);
      2'd2: dp_d  = 1'b0;
      2'd3: seg_d = hex7(addr_q);
      default: seg_d = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q     <= '0;
      addr_q      <= 4'd0;
      refresh_q   <= '0;
      digit_sel_q <= 2'd0;
      data_q      <= 8'd0;
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      dwell_q     <= dwell_d;
      addr_q      <= addr_d;
      refresh_q   <= refresh_d;
      digit_sel_q <= digit_sel_d;
      // Captured every cycle so processor writes show up without a rescan
      data_q      <= data_on_dmem;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign addr_on_dmem = addr_q;
  assign an           = an_q;
  assign seg          = seg_q;
  assign dp           = dp_q;

endmodule

// File: doc/dmem_display_scanner.md
# dmem_display_scanner

Debug front-end that sits directly downstream of the processor top level on the board. It drives the top's `addr_on_dmem` read port, sweeping through all 16 data-memory locations or holding/stepping under user control. It captures the returned `data_on_dmem` byte and time-multiplexes address and data onto a 4-digit common-anode seven-segment display. The block is purely observational: it never writes memory and never stalls the processor.

## Interface
- `DWELL_CYCLES`, default 100_000_000: clocks each address is shown in auto-scan; legal range ≥1.
- `REFRESH_CYCLES`, default 100_000: clocks each digit is lit per refresh slot; legal range ≥1.
- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `hold`  in  1  async button/switch: 1 freezes the address and enables manual stepping.
- `step`  in  1  async button: each rising edge advances the address by 1 while hold is active.
- `data_on_dmem`  in  8  byte returned by the top for `addr_on_dmem` (combinational read).
- `addr_on_dmem`  out  4  dmem address presented to the top.
- `an`  out  4  digit anodes, active-low; bit 3 is the leftmost digit.
- `seg`  out  7  segments, active-low, bit0=a … bit6=g.
- `dp`  out  1  decimal point, active-low.

## Operation
- Sync: `hold` and `step` each pass through a 2-flop synchronizer. A step pulse is generated when the synchronized step = 1 and its previous-cycle copy = 0. All control logic below uses synchronized values only.
- Auto-scan, synchronized hold = 0:
  - `dwell_cnt` counts 0..DWELL_CYCLES-1.
  - At terminal count, `addr_on_dmem` increments mod 16 (15→0) and `dwell_cnt`→0.
  - Step pulses are ignored.
- Hold, synchronized hold = 1:
  - `dwell_cnt` is forced to 0 and the address is frozen.
  - A step pulse increments the address mod 16.
  - After hold is released, the first auto increment occurs DWELL_CYCLES clocks later.
- Capture: `data_q` <= `data_on_dmem` every cycle, so dmem writes made by the processor appear on the display without waiting for rescan.
- Refresh:
  - `refresh_cnt` counts 0..REFRESH_CYCLES-1.
  - At terminal count, 2-bit `digit_sel` increments mod 4.
  - `digit_sel` runs regardless of hold.
- Digit content, by `digit_sel`:
  - 0 → `data_q[3:0]`.
  - 1 → `data_q[7:4]`.
  - 2 → blank (seg = 7'h7F), dp = 0 as separator.
  - 3 → `addr_on_dmem` hex.
  - dp = 1 on all other digits.
- Hex decode (active-low, gfedcba):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78.
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- `an` = ~(4'b0001 << `digit_sel`); exactly one digit is lit at any time after reset.

## Timing
- Reset (reset = 0, asynchronous assert):
  - `addr_on_dmem` = 0, `an` = 4'hF, `seg` = 7'h7F, `dp` = 1.
  - All counters, synchronizers, `data_q` and `digit_sel` = 0.
- Reset deassert is synchronous to clk by construction upstream. Asserting reset mid-scan or mid-step immediately returns everything to reset values; a pending step is discarded.
- `an`, `seg` and `dp` are registered, with 1-cycle latency from `digit_sel`/`data_q`/`addr_on_dmem`. The first edge after reset release drives `an` = 4'hE and `seg` = 7'h40.
- Displayed data lags dmem by 2 cycles: 1 cycle for `data_q`, 1 cycle for the output register.
- `step` going high before edge k produces its address increment at edge k+3: sync1 at k, sync2 at k+1, pulse registered at k+2.
- Holding `step` high yields exactly one increment; re-arm requires synchronized step = 0 for ≥1 cycle.
- If hold rises in the same cycle as the dwell terminal count, hold wins: no increment, and the counter clears.
- A step pulse arriving in the same cycle that synchronized hold falls is ignored.
- Counter widths are $clog2(N) with a minimum of 1 bit. With DWELL_CYCLES = 1 the address increments every cycle; likewise for REFRESH_CYCLES = 1.

## Test plan
- Reset/idle: use DWELL=8, REFRESH=2, hold = 0, and set dmem[0]=8'h3C. Assert reset then release. Required: outputs 4'hF/7'h7F/1 during reset; an = 4'hE first, then `seg` shows C (7'h46) on digit 0 and 3 (7'h30) on digit 1.
- Auto-scan wrap: run 16×8 cycles. Required: addr steps 0,1,…,15,0 every 8 clocks exactly; digit 3 shows the matching hex.
- Hold/step: set hold = 1 at addr 5, then pulse step 3× (each 4 cycles high). Required: addr 5→6→7→8, each change at edge k+3 of its pulse; no auto increments over 100 cycles.
- Step ignored / held high: with hold = 0, pulse step → no extra increment. With hold = 1, keep step high 50 cycles → exactly +1.
- Live capture: hold at addr 2; force `data_on_dmem` from 8'h00 to 8'hA7. Required: digits 1/0 show A (7'h08) / 7 (7'h78) within 2 cycles of their next lit slot.
- Reset mid-operation: assert reset 1 cycle after a step pulse is synchronized. Required: addr 0 immediately, no increment after release, and all outputs at reset values while reset = 0.
